// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding request port to APB master with address-decoded one-hot PSEL,
// PREADY wait states, access timeout and decode-error responses.
module apb_master_bridge #(
  parameter int SEL_LSB = 12,
  parameter int SEL_BITS = 2,
  parameter logic [31-SEL_LSB-SEL_BITS:0] BASE_HI = '0,
  parameter int TIMEOUT = 16,
  localparam int NUM_SLV = 2**SEL_BITS
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   req,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [31:0]            PADDR,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  output logic                   PENABLE,
  output logic [NUM_SLV-1:0]     PSEL,
  input  logic [32*NUM_SLV-1:0]  PRDATA_all,
  input  logic [NUM_SLV-1:0]     PREADY_all
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;
  logic [SEL_BITS-1:0] slv;
  logic [CW-1:0] cnt, cnt_nxt;
  logic accept, dec_err, ready, timeout, done;
  always_comb begin
    accept = state == IDLE && req;
    dec_err = req_addr[31:SEL_LSB+SEL_BITS] != BASE_HI;
    ready = state == ACCESS && PREADY_all[slv];
    cnt_nxt = cnt + CW'(1);
    timeout = TIMEOUT != 0 && cnt_nxt == CW'(TIMEOUT);
    done = state == ACCESS && (ready || timeout);
    state_nxt = state == IDLE ? (accept && !dec_err ? SETUP : IDLE) :
                state == SETUP ? ACCESS : (done ? IDLE : ACCESS);
    req_ready = state == IDLE;
    PENABLE = state == ACCESS;
    PSEL = state == IDLE ? '0 : NUM_SLV'(1) << slv;
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= IDLE;
    else state <= state_nxt;
  // PREADY beats a coincident timeout, so the error path requires !ready.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      PADDR <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      slv <= '0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done || (accept && dec_err);
      rsp_err <= (done && !ready) || (accept && dec_err);
      rsp_rdata <= ready && !PWRITE ? PRDATA_all[slv*32 +: 32] : '0;
      cnt <= state == ACCESS ? cnt_nxt : '0;
      if (accept) begin
        PADDR <= req_addr;
        PWRITE <= req_write;
        PWDATA <= req_wdata;
        slv <= req_addr[SEL_LSB +: SEL_BITS];
      end
    end
endmodule
